// File: rtl/mw_pkg.sv
// Shared definitions for the microwave cook timer: key codes, timer state
// encoding, the BCD mm:ss display record and a small BCD conversion helper.
package mw_pkg;

   localparam logic [3:0] KEY_START = 4'd10;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
   localparam logic [3:0] KEY_ADD30 = 4'd12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } mw_timer_state_t;

   // Four BCD digits, most significant first: {m1, m0, s1, s0}.
   typedef struct packed {
      logic [3:0] m1;
      logic [3:0] m0;
      logic [3:0] s1;
      logic [3:0] s0;
   } mmss_t;

   // Two-digit BCD encoding of a value in 0..99.
   function automatic logic [7:0] to_bcd8(input int unsigned v);
      to_bcd8 = {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/mmss_arith.sv
// Combinational BCD arithmetic on an mm:ss value: one-second decrement,
// clamp of the minutes field to MAX_MIN, zero detect and, when
// MW_TIMER_ADD30_EN is defined, the add-30-seconds rule with an overflow flag.
module mmss_arith
   import mw_pkg::*;
#(
   parameter int MAX_MIN = 99
) (
   input  mmss_t cur,
   output mmss_t dec,
   output logic  dec_zero,
   output mmss_t clamped,
   output logic  is_zero
`ifdef MW_TIMER_ADD30_EN
   ,
   output mmss_t add30,
   output logic  add_ovf
`endif
);

   localparam logic [6:0] MAX_MIN7    = 7'(MAX_MIN);
   localparam logic [7:0] MAX_MIN_BCD = to_bcd8(MAX_MIN);

   // Binary value of the minutes field, used for the MAX_MIN comparisons.
   logic [6:0] mm_val;
   assign mm_val = 7'(cur.m1) * 7'd10 + 7'(cur.m0);

   assign is_zero  = (cur == '0);
   assign dec_zero = (dec == '0);

   // Decrement by one second; seconds 60..99 count down as-is, no normalisation.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      dec = cur;
      if (cur.s1 != 4'd0 || cur.s0 != 4'd0) begin
         if (cur.s0 != 4'd0) begin
            dec.s0 = cur.s0 - 4'd1;
         end else begin
            dec.s0 = 4'd9;
            dec.s1 = cur.s1 - 4'd1;
         end
      end else begin
         dec.s1 = 4'd5;
         dec.s0 = 4'd9;
         if (cur.m0 != 4'd0) begin
            dec.m0 = cur.m0 - 4'd1;
         end else begin
            dec.m0 = 4'd9;
            dec.m1 = cur.m1 - 4'd1;
         end
      end
   end

   // Clamp minutes entered above MAX_MIN; seconds pass through.
   always_comb begin
      clamped = cur;
      if (mm_val > MAX_MIN7) begin
         {clamped.m1, clamped.m0} = MAX_MIN_BCD;
      end
   end

`ifdef MW_TIMER_ADD30_EN
   // Add 30 s; a minute carry at or beyond MAX_MIN flags overflow (key ignored).
   always_comb begin
      add30   = cur;
      add_ovf = 1'b0;
      if (cur.s1 < 4'd3) begin
         add30.s1 = cur.s1 + 4'd3;
      end else if (mm_val >= MAX_MIN7) begin
         add_ovf = 1'b1;
      end else begin
         add30.s1 = cur.s1 - 4'd3;
         if (cur.m0 == 4'd9) begin
            add30.m0 = 4'd0;
            add30.m1 = cur.m1 + 4'd1;
         end else begin
            add30.m0 = cur.m0 + 4'd1;
         end
      end
   end
`endif

endmodule

// File: rtl/microwave_timer.sv
// Keypad-driven microwave cook timer. Collects a BCD mm:ss cook time,
// pulses start to launch the oven, counts down on heated 1 Hz ticks and
// pulses finish at 00:00. Optional ADD30 key enabled by MW_TIMER_ADD30_EN.
module microwave_timer
   import mw_pkg::*;
#(
   parameter int MAX_MIN = 99
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        tick,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        heat,
   input  logic        door,
   output logic        start,
   output logic        finish,
   output logic [15:0] disp,
   output logic        running,
   output logic        done
);

   mw_timer_state_t state, state_n;
   mmss_t           disp_q, disp_n;
   logic            start_n, finish_n;
   logic            door_q;

   mmss_t dec_v, clamp_v;
   logic  dec_zero, cur_zero;

   logic key_digit, key_start, key_clear;
   logic door_rise, tick_dec;

`ifdef MW_TIMER_ADD30_EN
   mmss_t add_v;
   logic  add_ovf;
   logic  key_add;
   assign key_add = key_valid && (key_code == KEY_ADD30);
`endif

   assign key_digit = key_valid && (key_code <= 4'd9);
   assign key_start = key_valid && (key_code == KEY_START);
   assign key_clear = key_valid && (key_code == KEY_CLEAR);
   assign door_rise = door && !door_q;
   assign tick_dec  = tick && heat;

   mmss_arith #(
      .MAX_MIN (MAX_MIN)
   ) u_arith (
      .cur      (disp_q),
      .dec      (dec_v),
      .dec_zero (dec_zero),
      .clamped  (clamp_v),
      .is_zero  (cur_zero)
`ifdef MW_TIMER_ADD30_EN
      ,
      .add30    (add_v),
      .add_ovf  (add_ovf)
`endif
   );

   // State, display and pulse registers; reset clears everything with no pulse.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state  <= IDLE;
         disp_q <= '0;
         start  <= 1'b0;
         finish <= 1'b0;
         door_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state  <= state_n;
         disp_q <= disp_n;
         start  <= start_n;
         finish <= finish_n;
         door_q <= door;
      end
   end

   // Next-state logic: key handling, countdown and pulse requests.
   always_comb begin
      state_n  = state;
      disp_n   = disp_q;
      start_n  = 1'b0;
      finish_n = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (key_digit) begin
               disp_n  = '0;
               disp_n.s0 = key_code;
               state_n = ENTRY;
`ifdef MW_TIMER_ADD30_EN
            end else if (key_add) begin
               // Quick start: 00:30 and launch straight away if the door is shut.
               disp_n = 16'h0030;
               if (!door) begin
                  start_n = 1'b1;
                  state_n = RUN;
               end else begin
                  state_n = ENTRY;
               end
`endif
            end else if (state == DONE && (key_clear || door_rise)) begin
               state_n = IDLE;
            end
         end

         ENTRY: begin
            if (key_digit) begin
               disp_n = {disp_q[11:0], key_code};
            end else if (key_clear) begin
               disp_n  = '0;
               state_n = IDLE;
`ifdef MW_TIMER_ADD30_EN
            end else if (key_add) begin
               if (!add_ovf) disp_n = add_v;
`endif
            end else if (key_start && !cur_zero && !door) begin
               disp_n  = clamp_v;
               start_n = 1'b1;
               state_n = RUN;
            end
         end

         RUN: begin
            // An accepted key takes priority; the coincident tick is dropped.
            if (key_clear && !door) begin
               disp_n   = '0;
               finish_n = 1'b1;
               state_n  = IDLE;
`ifdef MW_TIMER_ADD30_EN
            end else if (key_add && !add_ovf) begin
               // A tick that would have reached 00:00 is honoured so the add lands on 00:30.
               disp_n = (tick_dec && dec_zero) ? mmss_t'(16'h0030) : add_v;
`endif
            end else if (tick_dec) begin
               disp_n = dec_v;
               if (dec_zero) begin
                  finish_n = 1'b1;
                  state_n  = DONE;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs decoded directly from state and the display register.
   always_comb begin
      running = (state == RUN);
      done    = (state == DONE);
      disp    = disp_q;
   end

endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard testbench for microwave_timer. Expected start/finish events are
// queued by the stimulus; a negedge monitor pops and compares each pulse.
// Status snapshots are checked directly with check().
`timescale 1ns/1ps
module tb_microwave_timer;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        tick = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        heat = 1'b0;
   logic        door = 1'b0;
   logic        start, finish, running, done;
   logic [15:0] disp;

   int n_checks = 0;
   int n_errors = 0;

   // Status word: {start, finish, running, done, disp}.
   localparam logic [3:0] S_IDLE = 4'b0000;
   localparam logic [3:0] S_RUN  = 4'b0010;
   localparam logic [3:0] S_DONE = 4'b0001;
   localparam logic [3:0] P_START = 4'b1010;
   localparam logic [3:0] P_FIN_DONE = 4'b0101;
   localparam logic [3:0] P_FIN_CLR  = 4'b0100;

   typedef struct {
      string       name;
      logic [19:0] status;
   } exp_t;

   exp_t exp_q[$];

   microwave_timer #(.MAX_MIN(99)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .tick      (tick),
      .key_valid (key_valid),
      .key_code  (key_code),
      .heat      (heat),
      .door      (door),
      .start     (start),
      .finish    (finish),
      .disp      (disp),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] status();
      return {start, finish, running, done, disp};
   endfunction

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got flags=%b disp=%h, want flags=%b disp=%h",
                  name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
      end
   endtask

   task automatic expect_pulse(input string name, input logic [3:0] flags, input logic [15:0] d);
      exp_t e;
      e.name   = name;
      e.status = {flags, d};
      exp_q.push_back(e);
   endtask

   // Monitor: every start/finish pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (nrst && (start || finish)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_pulse: got flags=%b disp=%h, want no pulse",
                     status() >> 16, disp);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (status() !== e.status) begin
               n_errors++;
               $display("FAIL %s: got flags=%b disp=%h, want flags=%b disp=%h",
                        e.name, status() >> 16, disp, e.status[19:16], e.status[15:0]);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("reset_outputs", status(), {S_IDLE, 16'h0000});
      @(negedge clk);
      nrst = 1'b1;
      heat = 1'b1;

      // 1:30 cook, 90 heated ticks to finish.
      press(4'd1); press(4'd3); press(4'd0);
      check("entry_0130", status(), {S_IDLE, 16'h0130});
      expect_pulse("start_0130", P_START, 16'h0130);
      press(4'd10);
      ticks(1);
      check("run_0129", status(), {S_RUN, 16'h0129});
      ticks(29);
      check("run_0100", status(), {S_RUN, 16'h0100});
      ticks(1);
      check("run_0059_borrow", status(), {S_RUN, 16'h0059});
      ticks(58);
      check("run_0001", status(), {S_RUN, 16'h0001});
      expect_pulse("finish_0130", P_FIN_DONE, 16'h0000);
      ticks(1);
      step();
      check("done_after_0130", status(), {S_DONE, 16'h0000});
      press(4'd11);
      check("done_clear_idle", status(), {S_IDLE, 16'h0000});

      // 5 s cook with a door pause: paused ticks and CLEAR are ignored.
      press(4'd5);
      expect_pulse("start_0005", P_START, 16'h0005);
      press(4'd10);
      ticks(1);
      door = 1'b1; heat = 1'b0;
      ticks(3);
      check("pause_ignores_tick", status(), {S_RUN, 16'h0004});
      press(4'd11);
      check("clear_door_open_ignored", status(), {S_RUN, 16'h0004});
      door = 1'b0; heat = 1'b1;
      ticks(3);
      check("resume_0001", status(), {S_RUN, 16'h0001});
      expect_pulse("finish_0005", P_FIN_DONE, 16'h0000);
      ticks(1);
      step();
      check("done_after_0005", status(), {S_DONE, 16'h0000});

      // Door rising in DONE returns to IDLE.
      door = 1'b1;
      step();
      step();
      check("door_rise_idle", status(), {S_IDLE, 16'h0000});
      door = 1'b0;

      // 0090 counts down as-is; CLEAR in RUN with door shut pulses finish.
      press(4'd9); press(4'd0);
      expect_pulse("start_0090", P_START, 16'h0090);
      press(4'd10);
      ticks(1);
      check("run_0089", status(), {S_RUN, 16'h0089});
      expect_pulse("finish_clear_0089", P_FIN_CLR, 16'h0000);
      press(4'd11);
      step();
      check("clear_run_idle", status(), {S_IDLE, 16'h0000});

      // 0100 borrows into 0059.
      press(4'd1); press(4'd0); press(4'd0);
      expect_pulse("start_0100", P_START, 16'h0100);
      press(4'd10);
      ticks(1);
      check("run_0100_to_0059", status(), {S_RUN, 16'h0059});
      expect_pulse("finish_clear_0059", P_FIN_CLR, 16'h0000);
      press(4'd11);
      step();

      // Digit shifting drops the oldest digit; CLEAR in ENTRY gives no pulse.
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      check("entry_shift_2345", status(), {S_IDLE, 16'h2345});
      press(4'd11);
      check("entry_clear", status(), {S_IDLE, 16'h0000});

      // Seconds above 59 count down unchanged.
      press(4'd7); press(4'd5);
      expect_pulse("start_0075", P_START, 16'h0075);
      press(4'd10);
      ticks(1);
      check("run_0074", status(), {S_RUN, 16'h0074});
      expect_pulse("finish_clear_0074", P_FIN_CLR, 16'h0000);
      press(4'd11);
      step();

      // START refused at 0000 and with the door open; code 13 ignored.
      press(4'd0);
      press(4'd10);
      check("start_zero_ignored", status(), {S_IDLE, 16'h0000});
      press(4'd5);
      door = 1'b1;
      press(4'd10);
      check("start_door_open_ignored", status(), {S_IDLE, 16'h0005});
      door = 1'b0;
      press(4'd13);
      check("key13_ignored", status(), {S_IDLE, 16'h0005});
      press(4'd11);

      // Reset mid-RUN clears everything at once with no finish.
      press(4'd4);
      expect_pulse("start_0004", P_START, 16'h0004);
      press(4'd10);
      ticks(1);
      check("run_0003", status(), {S_RUN, 16'h0003});
      #2;
      nrst = 1'b0;
      #1;
      check("reset_mid_run", status(), {S_IDLE, 16'h0000});
      @(negedge clk);
      nrst = 1'b1;

`ifdef MW_TIMER_ADD30_EN
      // Quick start from IDLE, then terminal tick coincident with ADD30.
      expect_pulse("start_add30", P_START, 16'h0030);
      press(4'd12);
      ticks(29);
      check("add30_run_0001", status(), {S_RUN, 16'h0001});
      @(negedge clk);
      tick = 1'b1; key_valid = 1'b1; key_code = 4'd12;
      @(negedge clk);
      tick = 1'b0; key_valid = 1'b0;
      check("terminal_tick_add30", status(), {S_RUN, 16'h0030});
      expect_pulse("finish_clear_0030", P_FIN_CLR, 16'h0000);
      press(4'd11);
      step();

      // ADD30 in RUN with minute carry.
      press(4'd4); press(4'd5);
      expect_pulse("start_0045", P_START, 16'h0045);
      press(4'd10);
      press(4'd12);
      check("add30_0045_to_0115", status(), {S_RUN, 16'h0115});
      expect_pulse("finish_clear_0115", P_FIN_CLR, 16'h0000);
      press(4'd11);
      step();

      // Saturation at 99 minutes.
      press(4'd9); press(4'd9); press(4'd1); press(4'd0);
      press(4'd12);
      check("add30_9910", status(), {S_IDLE, 16'h9940});
      press(4'd12);
      check("add30_9940_ignored", status(), {S_IDLE, 16'h9940});
      press(4'd11);

      // ADD30 from IDLE with the door open only loads 0030.
      door = 1'b1;
      press(4'd12);
      check("add30_door_open", status(), {S_IDLE, 16'h0030});
      door = 1'b0;
      press(4'd11);
`else
      // Code 12 behaves like an ignored code.
      press(4'd12);
      check("add30_idle_ignored", status(), {S_IDLE, 16'h0000});
      press(4'd5);
      press(4'd12);
      check("add30_entry_ignored", status(), {S_IDLE, 16'h0005});
      press(4'd11);
`endif

      step();
      step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending events, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Keypad-driven cook timer that sequences the microwave oven controller. It collects a BCD mm:ss cook time from the keypad and pulses `start` to launch cooking. It counts down once per second only while the oven reports `heat`, then pulses `finish` at 00:00. It sits between the keypad scanner, the 1 Hz tick generator and the oven FSM's `start`/`finish`/`heat`/`door` signals.

## Interface
- `MAX_MIN`, default 99: maximum minutes value, BCD-interpreted, 1..99.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle enable at 1 Hz.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 4: 0–9 digit, 10 START, 11 CLEAR, 12 ADD30; 13–15 ignored.
- `heat` in 1: oven magnetron on (oven in COOK).
- `door` in 1: door open.
- `start` out 1: one-cycle pulse to oven.
- `finish` out 1: one-cycle pulse to oven.
- `disp` out 16: BCD {m1,m0,s1,s0}.
- `running` out 1: state == RUN.
- `done` out 1: state == DONE.

## Operation
- States: IDLE, ENTRY, RUN, DONE. Reset: IDLE, `disp`=0000, `start`=`finish`=`running`=`done`=0.
- IDLE/DONE, digit d: `disp` <= 000d, go to ENTRY.
- IDLE/DONE, ADD30: `disp` <= 0030. If `door`=0, pulse `start` and go to RUN; else go to ENTRY.
- DONE, CLEAR or `door` rising: go to IDLE. START in IDLE/DONE is ignored.
- ENTRY, digit d: `disp` <= {disp[11:0], d}; the oldest digit drops out.
- ENTRY, CLEAR: `disp` <= 0, go to IDLE.
- ENTRY, ADD30: apply the add rule below.
- ENTRY, START: accepted only if `disp`≠0000 and `door`=0. Then pulse `start` and go to RUN; otherwise ignored.
- Minutes entered above MAX_MIN are clamped to MAX_MIN when START is accepted.
- Seconds fields 60–99 are legal and count down as-is; no normalisation.
- RUN, `tick` with `heat`=1, decrement:
  - if ss≠00: ss−1 (BCD);
  - else ss=59, mm−1 (BCD).
- RUN, `tick` with `heat`=0 (door pause): ignored.
- RUN, decrement reaching 0000: pulse `finish`, go to DONE.
- RUN, CLEAR: accepted only when `door`=0. Then pulse `finish`, `disp` <= 0, go to IDLE. Ignored while the door is open so the oven is never left in PAUSE with no timer.
- RUN, digit or START: ignored.
- Add rule (ADD30):
  - if ss<30: ss+30;
  - else ss−30, mm+1.
  - If mm==MAX_MIN and a carry would be needed, the key is ignored.
- All arithmetic is 4-bit BCD per digit. Digit keys never produce non-BCD values.

## Timing
- Key effects update registers on the edge where `key_valid`=1; visible on `disp` the next cycle.
- `start` is high exactly one cycle, the cycle after START/ADD30 is accepted. `running` rises the same cycle.
- `finish` is high exactly one cycle, the cycle after the terminal tick edge. `disp` reads 0000 that cycle and `done` rises.
- Simultaneous `tick` and accepted key in RUN: the key wins and the tick is dropped.
- Terminal tick plus ADD30 in the same cycle: the add applies and there is no `finish`.
- `nrst` asserted mid-RUN: immediate return to reset values, with no `finish` pulse.

## Configuration
- `MW_TIMER_ADD30_EN` defined: ADD30 key (code 12) behaves as above, including quick-start from IDLE/DONE.
- `MW_TIMER_ADD30_EN` undefined: code 12 is ignored like 13–15, and the add-rule logic is not built.

## Structure
- Shared package `mw_pkg`:
  - key-code constants `KEY_START`=10, `KEY_CLEAR`=11, `KEY_ADD30`=12;
  - timer state enum `mw_timer_state_t`;
  - `mmss_t` struct of four 4-bit BCD digits.
- Sub-module `mmss_arith`: combinational BCD decrement, add-30 with carry/overflow flag, clamp to MAX_MIN, and zero detect. The FSM and registers stay in `microwave_timer`.

## Test plan
- Keys 1,3,0, then START with door=0 → `disp`=0130; `start` pulses once; after 90 heat-ticks `disp`=0000, `finish` pulses one cycle, `done`=1.
- Entry 0005, START, then door=1 (heat=0) for 3 ticks, then door=0 → ticks while paused are ignored; `finish` arrives after exactly 5 heat-ticks.
- IDLE, ADD30 with door=0 → `disp`=0030, `start` pulses; ADD30 at 0045 in RUN → 0115; at mm=99, ss=40 → unchanged.
- Entry 0090 runs 0090→0089…; entry 0100 runs through 0059 after one tick.
- RUN with door=1: CLEAR ignored. RUN with door=0: CLEAR gives `finish` pulse, `disp`=0000, IDLE.
- Terminal tick coincident with ADD30 → `disp`=0030, no `finish`. `nrst` low mid-RUN → all outputs 0 at once.
